// File: rtl/hellow_world_button_edge_pio.sv
// hellow_world_button_edge_pio
//   Memory-mapped input PIO for push buttons. Each input bit is synchronised,
//   debounced and edge-detected. Captured edges can raise a maskable level
//   interrupt so software does not have to poll the buttons.
//
//   Register map (32-bit, bits above WIDTH-1 read 0):
//     0 DATA     read-only, debounced input value
//     1 reserved reads 0
//     2 IRQMASK  read/write
//     3 EDGECAP  read, write-1-to-clear per bit
//
//   Ports:
//     clk        system clock
//     reset      synchronous, active-high reset
//     address    register select
//     chipselect slave select, qualifies writes
//     write_n    active-low write strobe
//     writedata  write data
//     in_port    asynchronous button inputs
//     readdata   registered read data (1-cycle latency)
//     irq        level interrupt, |(EDGECAP & IRQMASK)
module hellow_world_button_edge_pio #(
    parameter int WIDTH           = 2,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int EDGE_MODE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0]                  deb_q, deb_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  irqmask_q, irqmask_d;
    logic [WIDTH-1:0]                  edgecap_q, edgecap_d;
    logic [31:0]                       readdata_q, readdata_d;

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic             wr_en;

    // Writes only ever use the low WIDTH bits; fold the rest so nothing dangles.
    logic unused_wdata;
    assign unused_wdata = ^writedata;

    assign s     = sync_q[SYNC_STAGES-1];
    assign wr_en = chipselect & ~write_n;

    // Synchroniser chain: stage 0 samples the raw pins.
    always_comb begin
        sync_d[0] = in_port;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Debounce: any cycle where s matches d restarts the count, so only a
    // difference held for DEBOUNCE_CYCLES consecutive cycles is accepted.
    always_comb begin
        deb_d = deb_q;
        cnt_d = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                deb_d[i] = s[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Edge events are taken from the debounced value as it updates, so
    // EDGECAP sets on the same clock edge as d.
    always_comb begin
        case (EDGE_MODE)
            0:       evt = deb_d & ~deb_q;
            1:       evt = ~deb_d & deb_q;
            default: evt = deb_d ^ deb_q;
        endcase
    end

    // Register writes. A new event overrides a simultaneous clear.
    always_comb begin
        irqmask_d = irqmask_q;
        clr       = '0;
        if (wr_en && address == 2'd2) begin
            irqmask_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == 2'd3) begin
            clr = writedata[WIDTH-1:0];
        end
        edgecap_d = (edgecap_q & ~clr) | evt;
    end

    // Read mux samples the pre-write register state every cycle.
    always_comb begin
        readdata_d = '0;
        case (address)
            2'd0:    readdata_d[WIDTH-1:0] = deb_q;
            2'd2:    readdata_d[WIDTH-1:0] = irqmask_q;
            2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
            default: readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q     <= '0;
            deb_q      <= '0;
            cnt_q      <= '0;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            sync_q     <= sync_d;
            deb_q      <= deb_d;
            cnt_q      <= cnt_d;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_hellow_world_button_edge_pio.sv
module tb_hellow_world_button_edge_pio;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'h0;
    logic [1:0]  in_port    = 2'b00;
    logic [31:0] readdata;
    logic        irq;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hellow_world_button_edge_pio #(
        .WIDTH(2),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .EDGE_MODE(0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    // Advance one rising edge; everything is sampled/driven 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        in_port    = 2'b00;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), v);
            checks++;
            if (v !== 32'h0) begin
                errors++;
                $display("FAIL reset_read addr=%0d got=%h exp=00000000", a, v);
            end
        end
        // Upper bits of IRQMASK are not writable; DATA/reserved ignore writes.
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, v);
        checks++;
        if (v !== 32'h3) begin
            errors++;
            $display("FAIL mask_width got=%h exp=00000003", v);
        end
        wr(2'd0, 32'hFF);
        wr(2'd1, 32'hFF);
        rd(2'd0, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL data_ro got=%h exp=00000000", v);
        end
        rd(2'd1, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL reserved got=%h exp=00000000", v);
        end
    endtask

    task automatic test_debounce_latency();
        logic [31:0] exp;
        do_reset();
        address = 2'd0;
        in_port = 2'b01;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp = (t == 7) ? 32'h1 : 32'h0;
            checks++;
            if (readdata !== exp) begin
                errors++;
                $display("FAIL latency t=%0d got=%h exp=%h", t, readdata, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [31:0] v;
        logic [31:0] exp;
        do_reset();
        address = 2'd0;
        in_port = 2'b10;
        repeat (3) tick();
        in_port = 2'b00;
        for (int t = 0; t < 8; t++) begin
            tick();
            checks++;
            if (readdata !== 32'h0) begin
                errors++;
                $display("FAIL glitch3_data t=%0d got=%h exp=00000000", t, readdata);
            end
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'h0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL glitch3_cap got=%h irq=%b exp=00000000 irq=0", v, irq);
        end
        // Four-cycle pulse is just long enough to be accepted.
        address = 2'd0;
        in_port = 2'b10;
        repeat (4) tick();
        in_port = 2'b00;
        for (int t = 5; t <= 7; t++) begin
            tick();
            exp = (t == 7) ? 32'h2 : 32'h0;
            checks++;
            if (readdata !== exp) begin
                errors++;
                $display("FAIL glitch4_data t=%0d got=%h exp=%h", t, readdata, exp);
            end
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'h2 || irq !== 1'b0) begin
            errors++;
            $display("FAIL glitch4_cap got=%h irq=%b exp=00000002 irq=0", v, irq);
        end
    endtask

    task automatic test_irq_flow();
        logic [31:0] v;
        logic        exp;
        do_reset();
        wr(2'd2, 32'h1);
        in_port = 2'b01;
        for (int t = 1; t <= 6; t++) begin
            tick();
            exp = (t == 6);
            checks++;
            if (irq !== exp) begin
                errors++;
                $display("FAIL irq_rise t=%0d got=%b exp=%b", t, irq, exp);
            end
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL irq_cap got=%h exp=00000001", v);
        end
        wr(2'd3, 32'h1);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got=%b exp=0", irq);
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'h0) begin
            errors++;
            $display("FAIL cap_clear got=%h exp=00000000", v);
        end
        in_port = 2'b11;
        repeat (6) tick();
        rd(2'd3, v);
        checks++;
        if (v !== 32'h2 || irq !== 1'b0) begin
            errors++;
            $display("FAIL masked_cap got=%h irq=%b exp=00000002 irq=0", v, irq);
        end
        rd(2'd0, v);
        checks++;
        if (v !== 32'h3) begin
            errors++;
            $display("FAIL irq_data got=%h exp=00000003", v);
        end
    endtask

    task automatic test_collision();
        logic [31:0] v;
        do_reset();
        in_port = 2'b01;
        repeat (5) tick();
        // Clear lands on the same edge that d[0] rises.
        address    = 2'd3;
        writedata  = 32'h1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        checks++;
        if (readdata !== 32'h0) begin
            errors++;
            $display("FAIL collide_pre got=%h exp=00000000", readdata);
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'h1) begin
            errors++;
            $display("FAIL collide_set got=%h exp=00000001", v);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        logic [31:0] exp;
        do_reset();
        in_port = 2'b11;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        tick();
        reset   = 1'b0;
        address = 2'd0;
        for (int t = 1; t <= 7; t++) begin
            tick();
            exp = (t == 7) ? 32'h3 : 32'h0;
            checks++;
            if (readdata !== exp) begin
                errors++;
                $display("FAIL reset_mid_data t=%0d got=%h exp=%h", t, readdata, exp);
            end
        end
        rd(2'd3, v);
        checks++;
        if (v !== 32'h3) begin
            errors++;
            $display("FAIL reset_mid_cap got=%h exp=00000003", v);
        end
    endtask

    initial begin
        test_reset();
        test_debounce_latency();
        test_glitch();
        test_irq_flow();
        test_collision();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hellow_world_button_edge_pio.md
# hellow_world_button_edge_pio

Parametrised, memory-mapped input PIO with per-bit synchronisation, debouncing, edge capture and a maskable level interrupt. It replaces the fixed 2-bit, data-only button port on the Avalon-MM slave fabric. The CPU can read a clean, debounced button state and can take an interrupt on press and/or release instead of polling.

## Interface
- WIDTH, 2, number of input bits (1..32)
- SYNC_STAGES, 2, flip-flops in the input synchroniser chain (>=2)
- DEBOUNCE_CYCLES, 50000, consecutive cycles a synchronised input must differ from the debounced value before it is accepted (>=1)
- EDGE_MODE, 0, edges captured: 0 rising, 1 falling, 2 both
- clk  in  1  system clock; the only clock
- reset  in  1  synchronous, active-high reset
- address  in  2  register select
- chipselect  in  1  slave select, qualifies writes
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- in_port  in  WIDTH  asynchronous button inputs
- readdata  out  32  registered read data
- irq  out  1  level interrupt, active-high

## Operation
- Register map:
  - 0: DATA, read-only, debounced value in bits [WIDTH-1:0].
  - 1: reserved, reads 0.
  - 2: IRQMASK, read/write, bits [WIDTH-1:0].
  - 3: EDGECAP, read, write-1-to-clear per bit.
- Bits above WIDTH-1 read 0. Writes to them are ignored. Writes to addresses 0 and 1 are ignored.
- A write occurs on a cycle with chipselect=1 and write_n=0. Reads have no side effects.
- Synchroniser:
  - Each bit of in_port passes through SYNC_STAGES flops, giving s[i].
- Debounce, per bit:
  - State is the debounced value d[i] and a counter cnt[i] of width clog2(DEBOUNCE_CYCLES+1).
  - If s[i]==d[i], cnt[i] is cleared to 0.
  - Otherwise, if cnt[i]==DEBOUNCE_CYCLES-1, d[i] takes s[i] and cnt[i] is cleared to 0.
  - Otherwise, cnt[i] increments.
  - Any cycle with s[i]==d[i] restarts the count, so glitches shorter than DEBOUNCE_CYCLES are rejected.
- Edge capture:
  - An edge event is a change of d[i] that matches EDGE_MODE.
  - On the clock edge where d[i] updates with a matching event, EDGECAP[i] is set to 1.
  - EDGECAP[i] stays set until it is cleared by a write of 1 to that bit.
- Clear vs set collision:
  - If a clear of bit i and a new event on bit i occur in the same cycle, set wins and the bit stays 1.
- irq = |(EDGECAP & IRQMASK), decoded from registers only. There is no combinational path from in_port or the bus to irq.
- Reset values: all synchroniser flops, d, cnt, IRQMASK, EDGECAP and readdata are 0, so irq=0.
  - If an input is held high through reset, d rises DEBOUNCE_CYCLES cycles after the synchroniser fills.
  - That rise is a real rising edge and sets EDGECAP in modes 0 and 2. This is intended behaviour.

## Timing
- Read latency is 1 cycle.
  - readdata is registered every cycle from the address mux, independent of chipselect.
  - readdata shows the register contents as they were before any write in the same cycle.
- Write effect is visible to the register 1 cycle after the write cycle. irq follows in the same cycle as the register change.
- Input to DATA latency: an in_port change held stable becomes d after SYNC_STAGES+DEBOUNCE_CYCLES rising edges, and is readable 1 cycle later.
- EDGECAP sets on the same edge as d. irq asserts on that edge if the bit is masked in.
- With DEBOUNCE_CYCLES=1, d follows s with one cycle of delay, and no filtering occurs.
- Reset asserted mid-debounce clears cnt and d immediately on the next edge. The prior partial count is discarded.

## Test plan
Parameters for all scenarios: WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, EDGE_MODE=0.
- Reset: assert reset for 2 cycles with in_port=2'b00. Reads of addresses 0-3 all return 32'h0, and irq=0.
- Debounce latency: step in_port to 2'b01 at edge N and hold address=0.
  - d[0]=1 at edge N+6 and readdata=32'h1 after edge N+7.
  - No earlier read returns 1.
- Glitch rejection: pulse in_port[1] high for 3 cycles, then low.
  - DATA stays 32'h0, EDGECAP stays 0 and irq stays 0.
  - Repeat with a 4-cycle pulse: DATA bit 1 goes high, and EDGECAP reads 32'h2.
- Interrupt flow: write IRQMASK=32'h1, then raise in_port[0].
  - EDGECAP=32'h1 and irq=1 on the d edge.
  - Write 32'h1 to address 3: EDGECAP=0 and irq=0 one cycle later.
  - Raise bit 1 with mask bit 1 = 0: EDGECAP=32'h2 and irq stays 0.
- Set/clear collision: time a write-1-to-clear of bit 0 to coincide with a new rising d[0]. EDGECAP[0] reads 1 afterwards.
- Reset mid-debounce: drive in_port=2'b11 and assert reset 2 cycles into the debounce count.
  - After release, DATA becomes 32'h3 exactly 6 cycles later.
  - EDGECAP becomes 32'h3, with no stale count carried over.
